// File: rtl/sram_axi_bridge_pkg.sv
// Shared constants and request payload types for the SRAM-to-AXI bridge.
package sram_axi_bridge_pkg;

  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
  } aw_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_req_t;

endpackage

// File: rtl/sram_axi_bridge_req_slot.sv
// Single-entry valid+payload holding register; loads on grant, empties on ready.
module axi_req_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  // load only ever happens while the slot is empty, so it cannot collide with ready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridges the core's SRAM-style fetch and load/store channels onto single-beat AXI.
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [2:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  logic    rst_done;
  logic    inst_out, data_rd_out, wr_out;
  logic    data_rd_req, rd_ok_data, wr_ok;
  logic    inst_acc, data_rd_acc, wr_acc;
  logic    r_inst, r_data, b_done;
  ar_req_t ar_next, ar_q;
  aw_req_t aw_next, aw_q;
  w_req_t  w_next, w_q;

  // Held low for the first cycle after reset so handshake outputs stay quiet until then
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_done <= 1'b0;
    else         rst_done <= 1'b1;
  end

  assign data_rd_req  = data_req && !data_wr;
  assign rd_ok_data   = rst_done && !arvalid && !data_rd_out && !wr_out;
  assign wr_ok        = rst_done && !awvalid && !wvalid && !wr_out && !data_rd_out;
  assign data_addr_ok = data_wr ? wr_ok : rd_ok_data;
  assign inst_addr_ok = rst_done && !arvalid && !inst_out && !data_rd_req;

  assign inst_acc    = inst_req && inst_addr_ok;
  assign data_rd_acc = data_rd_req && data_addr_ok;
  assign wr_acc      = data_req && data_wr && data_addr_ok;

  assign r_inst = rst_done && rvalid && (rid == ID_INST);
  assign r_data = rst_done && rvalid && (rid == ID_DATA);
  assign b_done = rst_done && bvalid;

  always_comb begin
    ar_next = '{id: ID_INST, addr: inst_addr, size: SIZE_WORD};
    if (data_rd_acc) ar_next = '{id: ID_DATA, addr: data_addr, size: data_size};
    aw_next = '{addr: data_addr, size: data_size};
    w_next  = '{data: data_wdata, strb: data_wstrb};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_out    <= 1'b0;
      data_rd_out <= 1'b0;
      wr_out      <= 1'b0;
    end else begin
      if (inst_acc)         inst_out <= 1'b1;
      else if (r_inst)      inst_out <= 1'b0;
      if (data_rd_acc)      data_rd_out <= 1'b1;
      else if (r_data)      data_rd_out <= 1'b0;
      if (wr_acc)           wr_out <= 1'b1;
      else if (b_done)      wr_out <= 1'b0;
    end
  end

  axi_req_slot #(.W($bits(ar_req_t))) u_ar_slot (
    .clk(clk), .resetn(resetn), .load(inst_acc || data_rd_acc), .load_data(ar_next),
    .ready(arready), .valid(arvalid), .data(ar_q)
  );

  axi_req_slot #(.W($bits(aw_req_t))) u_aw_slot (
    .clk(clk), .resetn(resetn), .load(wr_acc), .load_data(aw_next),
    .ready(awready), .valid(awvalid), .data(aw_q)
  );

  axi_req_slot #(.W($bits(w_req_t))) u_w_slot (
    .clk(clk), .resetn(resetn), .load(wr_acc), .load_data(w_next),
    .ready(wready), .valid(wvalid), .data(w_q)
  );

  assign arid    = ar_q.id;
  assign araddr  = ar_q.addr;
  assign arsize  = ar_q.size;
  assign arlen   = LEN_SINGLE;
  assign arburst = BURST_INCR;

  assign awid    = ID_DATA;
  assign awaddr  = aw_q.addr;
  assign awsize  = aw_q.size;
  assign awlen   = LEN_SINGLE;
  assign awburst = BURST_INCR;
  assign wdata   = w_q.data;
  assign wstrb   = w_q.strb;
  assign wlast   = 1'b1;

  assign rready       = rst_done;
  assign bready       = rst_done;
  assign inst_data_ok = r_inst;
  assign inst_rdata   = rdata;
  assign data_data_ok = r_data || b_done;
  assign data_rdata   = rdata;

endmodule
